// File: rtl/edge_detector_pkg.sv
// Shared types for the multi-channel edge detector: per-channel mode encoding
// and the debounce FSM state type.
package edge_detector_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } mode_e;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } db_state_e;

    function automatic logic rise_enabled(input logic [1:0] mode);
        return (mode == MODE_RISE) || (mode == MODE_BOTH);
    endfunction

    function automatic logic fall_enabled(input logic [1:0] mode);
        return (mode == MODE_FALL) || (mode == MODE_BOTH);
    endfunction

endpackage

// File: rtl/edge_channel.sv
// One input channel: synchronizer, debounce FSM, edge pulses and sticky
// pending/overrun status with write-one-to-clear.
module edge_channel
    import edge_detector_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sign_in,
    input  logic [1:0] mode,
    input  logic       clr,
    output logic       pulse_p,
    output logic       pulse_n,
    output logic       level,
    output logic       pending,
    output logic       overrun
);

    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    db_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_d;
    logic                   update;

    logic                   rise_evt, fall_evt, evt;
    logic                   pending_d, overrun_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sign_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // The level update is decided combinationally so the pulse and pending
    // flops can be loaded on the very edge the filtered level changes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level;
        update  = 1'b0;
        case (state_q)
            ST_STABLE: begin
                if (s != level) begin
                    if (DEBOUNCE_CNT == 1) begin
                        level_d = s;
                        update  = 1'b1;
                    end else begin
                        state_d = ST_COUNT;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            ST_COUNT: begin
                if (s == level) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    level_d = s;
                    update  = 1'b1;
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        rise_evt = update &  level_d & rise_enabled(mode);
        fall_evt = update & ~level_d & fall_enabled(mode);
        evt      = rise_evt | fall_evt;

        pending_d = pending;
        overrun_d = overrun;
        if (evt) begin
            // A new event outranks a simultaneous clear.
            pending_d = 1'b1;
            overrun_d = clr ? 1'b0 : (overrun | pending);
        end else if (clr) begin
            pending_d = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            level   <= 1'b0;
            pulse_p <= 1'b0;
            pulse_n <= 1'b0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level   <= level_d;
            pulse_p <= rise_evt;
            pulse_n <= fall_evt;
            pending <= pending_d;
            overrun <= overrun_d;
        end
    end

endmodule

// File: rtl/multi_edge_detector.sv
// N_CH independent debounced edge-detector channels with a registered
// interrupt that is the OR of all pending flags.
module multi_edge_detector
    import edge_detector_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   sign_in,
    input  logic [2*N_CH-1:0] mode,
    input  logic [N_CH-1:0]   clr,
    output logic [N_CH-1:0]   pulse_out_p,
    output logic [N_CH-1:0]   pulse_out_n,
    output logic [N_CH-1:0]   level,
    output logic [N_CH-1:0]   pending,
    output logic [N_CH-1:0]   overrun,
    output logic              irq
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        edge_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .DEBOUNCE_CNT (DEBOUNCE_CNT)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .sign_in (sign_in[i]),
            .mode    (mode[2*i +: 2]),
            .clr     (clr[i]),
            .pulse_p (pulse_out_p[i]),
            .pulse_n (pulse_out_n[i]),
            .level   (level[i]),
            .pending (pending[i]),
            .overrun (overrun[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |pending;
        end
    end

endmodule

// File: doc/multi_edge_detector.md
MULTI_EDGE_DETECTOR -- requirements
Module: multi_edge_detector

Interface
REQ-001 Parameter: N_CH, default 4, number of independent input channels (1..32).
REQ-002 Parameter: SYNC_STAGES, default 2, synchronizer flops per channel (2..4).
REQ-003 Parameter: DEBOUNCE_CNT, default 3, consecutive differing samples needed to accept a level change (1..255).
REQ-004 Port: clk, input, 1, sole clock; all flops rising-edge.
REQ-005 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port: sign_in, input, N_CH, asynchronous raw inputs, one bit per channel.
REQ-007 Port: mode, input, 2*N_CH, per channel {mode[2i+1], mode[2i]}: 00 off, 01 rising, 10 falling, 11 both.
REQ-008 Port: clr, input, N_CH, per-channel write-one-to-clear of pending and overrun.
REQ-009 Port: pulse_out_p, output, N_CH, one-cycle rising-edge pulse per channel.
REQ-010 Port: pulse_out_n, output, N_CH, one-cycle falling-edge pulse per channel.
REQ-011 Port: level, output, N_CH, debounced (filtered) level per channel.
REQ-012 Port: pending, output, N_CH, sticky event flag per channel.
REQ-013 Port: overrun, output, N_CH, sticky flag: event while pending already set.
REQ-014 Port: irq, output, 1, registered OR of pending.

Function
REQ-015 Each channel SHALL pass sign_in[i] through SYNC_STAGES flops; synchronized value s first reflects an input change after SYNC_STAGES edges.
REQ-016 Per-channel debounce FSM SHALL have states STABLE (s == level) and COUNT (s != level) with counter width ceil(log2(DEBOUNCE_CNT+1)).
REQ-017 STABLE -> COUNT when s != level, counter <= 1; if DEBOUNCE_CNT == 1 the level update happens on that same edge instead.
REQ-018 In COUNT, s == level SHALL return to STABLE and clear the counter (glitch rejected, no pulse).
REQ-019 In COUNT, s != level on the edge where counter reaches DEBOUNCE_CNT SHALL set level <= s, clear counter, return to STABLE.
REQ-020 Total latency: a clean input step SHALL update level and assert the pulse SYNC_STAGES + DEBOUNCE_CNT edges after the first sampling edge (default 5).
REQ-021 pulse_out_p[i] SHALL be high for exactly one cycle when level[i] goes 0->1 and mode[i] is 01 or 11; pulse_out_n[i] likewise for 1->0 and mode 10 or 11.
REQ-022 Mode 00 SHALL suppress pulses and pending updates but level tracking continues; mode changes take effect on the next edge.
REQ-023 An enabled pulse SHALL set pending[i] on the same edge the pulse is registered.
REQ-024 An enabled pulse while pending[i] is already 1 (and clr[i] low) SHALL set overrun[i].
REQ-025 clr[i] SHALL clear pending[i] and overrun[i] next edge; clr coincident with a new event: event wins, pending = 1, overrun = 0.
REQ-026 irq SHALL be registered, lagging pending by one cycle.
REQ-027 Channels SHALL be fully independent; simultaneous events on all channels SHALL all be reported.

Reset
REQ-028 rst_n low SHALL asynchronously clear synchronizers, level, counters, FSM (STABLE), pulses, pending, overrun and irq to 0.
REQ-029 An input held high through reset release SHALL produce one rising pulse after the REQ-020 latency (if enabled); reset mid-count SHALL discard the count.

Structure
REQ-030 Mode encodings (MODE_OFF/RISE/FALL/BOTH) and FSM state type SHALL live in shared package edge_detector_pkg.
REQ-031 Per-channel logic SHALL be sub-module edge_channel, instantiated N_CH times by generate loop; irq OR in the top.

Verification
REQ-032 Default params, ch0 mode 01, sign_in[0] 0->1 held -> pulse_out_p[0] one cycle, 5 edges after sampling; pending[0]=1, irq=1 one cycle later.
REQ-033 ch1 mode 11, 2-cycle high glitch on sign_in[1] (DEBOUNCE_CNT=3) -> no pulse, level[1] stays 0.
REQ-034 ch2 mode 10, two falling edges without clr -> pending[2]=1, overrun[2]=1; clr[2]=1 one cycle -> both 0.
REQ-035 clr[3] asserted on the pulse cycle of ch3 -> pending[3]=1, overrun[3]=0.
REQ-036 All channels mode 11, simultaneous 0->1 on sign_in=4'b1111 -> pulse_out_p=4'b1111 same cycle; mode 00 channel -> level toggles, no pulse.
REQ-037 rst_n low during COUNT, input held high, release -> single rising pulse exactly 5 edges after release.
